// File: rtl/custom_axi_ip_pkg.sv
// rtl/custom_axi_ip_pkg.sv - shared types for the multi-channel processing IP
package custom_axi_ip_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DONE  = 2'd2,
    ERROR = 2'd3
  } status_e;

  typedef enum logic [1:0] {
    MODE_WRAP  = 2'd0,
    MODE_SAT   = 2'd1,
    MODE_CHECK = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    ERR_NONE      = 2'd0,
    ERR_ZERO_ITER = 2'd1,
    ERR_OVERFLOW  = 2'd2
  } err_e;

endpackage

// File: rtl/custom_axi_ip_rr_arb.sv
// rtl/custom_axi_ip_rr_arb.sv - combinational round-robin arbiter, search starts after last
module custom_axi_ip_rr_arb #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic [N-1:0] grant,
  output logic [W-1:0] grant_idx,
  output logic         any
);

  int idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = 0;
    for (int i = 1; i <= N; i++) begin
      idx = (int'(last) + i) % N;
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = W'(idx);
      end
    end
  end

endmodule

// File: rtl/custom_axi_ip_mc.sv
// rtl/custom_axi_ip_mc.sv - multi-channel increment/decrement engine with round-robin job grant
module custom_axi_ip_mc
  import custom_axi_ip_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH     = 4,
  parameter int ITER_WIDTH = 8,
  parameter int CH_W       = $clog2(NUM_CH)
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NUM_CH-1:0]              start_i,
  input  logic [NUM_CH*DATA_WIDTH-1:0]   data_i,
  input  logic [NUM_CH*ITER_WIDTH-1:0]   iter_i,
  input  mode_e                          mode_i,
  input  logic                           dir_i,
  input  logic                           clear_err_i,
  output status_e                        status_o,
  output logic [CH_W-1:0]                active_ch_o,
  output logic [NUM_CH-1:0]              pending_o,
  output logic [DATA_WIDTH-1:0]          result_o,
  output logic [CH_W-1:0]                result_ch_o,
  output logic                           result_valid_o,
  output logic                           sat_o,
  output err_e                           err_code_o
);

  status_e               state_q;
  mode_e                 mode_q;
  err_e                  err_q;
  logic                  dir_q;
  logic                  sat_q;
  logic                  result_valid_q;
  logic [NUM_CH-1:0]     pending_q;
  logic [CH_W-1:0]       ch_q;
  logic [CH_W-1:0]       last_q;
  logic [CH_W-1:0]       result_ch_q;
  logic [DATA_WIDTH-1:0] acc_q;
  logic [DATA_WIDTH-1:0] acc_d;
  logic [DATA_WIDTH-1:0] result_q;
  logic [ITER_WIDTH-1:0] rem_q;

  logic [NUM_CH-1:0]     req;
  logic [NUM_CH-1:0]     grant;
  logic [CH_W-1:0]       grant_idx;
  logic                  grant_any;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [ITER_WIDTH-1:0] sel_iter;
  logic                  ovf;

  // A start arriving in the grant cycle competes immediately, so it never leaves a stale pending bit.
  assign req = pending_q | start_i;

  custom_axi_ip_rr_arb #(.N(NUM_CH), .W(CH_W)) u_arb (
    .req       (req),
    .last      (last_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (grant_any)
  );

  always_comb begin
    sel_data = '0;
    sel_iter = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (grant[c]) begin
        sel_data = data_i[c*DATA_WIDTH +: DATA_WIDTH];
        sel_iter = iter_i[c*ITER_WIDTH +: ITER_WIDTH];
      end
    end
  end

  always_comb begin
    ovf   = dir_q ? (acc_q == '0) : (acc_q == '1);
    acc_d = dir_q ? acc_q - 1'b1 : acc_q + 1'b1;
    if (ovf && mode_q == MODE_SAT) acc_d = acc_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= IDLE;
      mode_q         <= MODE_WRAP;
      err_q          <= ERR_NONE;
      dir_q          <= 1'b0;
      sat_q          <= 1'b0;
      result_valid_q <= 1'b0;
      pending_q      <= '0;
      ch_q           <= '0;
      last_q         <= CH_W'(NUM_CH - 1);
      result_ch_q    <= '0;
      acc_q          <= '0;
      result_q       <= '0;
      rem_q          <= '0;
    end else begin
      result_valid_q <= 1'b0;
      pending_q      <= pending_q | start_i;
      case (state_q)
        IDLE: begin
          if (grant_any) begin
            pending_q <= req & ~grant;
            last_q    <= grant_idx;
            ch_q      <= grant_idx;
            acc_q     <= sel_data;
            rem_q     <= sel_iter;
            mode_q    <= mode_i;
            dir_q     <= dir_i;
            sat_q     <= 1'b0;
            if (sel_iter == '0) begin
              state_q <= ERROR;
              err_q   <= ERR_ZERO_ITER;
            end else begin
              state_q <= BUSY;
            end
          end
        end
        BUSY: begin
          if (ovf && mode_q == MODE_CHECK) begin
            state_q <= ERROR;
            err_q   <= ERR_OVERFLOW;
          end else begin
            acc_q <= acc_d;
            rem_q <= rem_q - 1'b1;
            if (ovf && mode_q == MODE_SAT) sat_q <= 1'b1;
            if (rem_q == ITER_WIDTH'(1)) begin
              state_q        <= DONE;
              result_q       <= acc_d;
              result_ch_q    <= ch_q;
              result_valid_q <= 1'b1;
            end
          end
        end
        DONE: state_q <= IDLE;
        ERROR: if (clear_err_i) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign status_o       = state_q;
  assign active_ch_o    = ch_q;
  assign pending_o      = pending_q;
  assign result_o       = result_q;
  assign result_ch_o    = result_ch_q;
  assign result_valid_o = result_valid_q;
  assign sat_o          = sat_q;
  assign err_code_o     = err_q;

endmodule

// File: tb/tb_custom_axi_ip_mc.sv
// tb/tb_custom_axi_ip_mc.sv - directed vector bench for custom_axi_ip_mc
module tb_custom_axi_ip_mc;
  import custom_axi_ip_pkg::*;

  localparam int DW = 32;
  localparam int NC = 4;
  localparam int IW = 8;
  localparam int CW = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NC-1:0]    start_i;
  logic [NC*DW-1:0] data_i;
  logic [NC*IW-1:0] iter_i;
  mode_e            mode_i;
  logic             dir_i;
  logic             clear_err_i;
  status_e          status_o;
  logic [CW-1:0]    active_ch_o;
  logic [NC-1:0]    pending_o;
  logic [DW-1:0]    result_o;
  logic [CW-1:0]    result_ch_o;
  logic             result_valid_o;
  logic             sat_o;
  err_e             err_code_o;

  always #5 clk = ~clk;

  custom_axi_ip_mc #(.DATA_WIDTH(DW), .NUM_CH(NC), .ITER_WIDTH(IW)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .start_i        (start_i),
    .data_i         (data_i),
    .iter_i         (iter_i),
    .mode_i         (mode_i),
    .dir_i          (dir_i),
    .clear_err_i    (clear_err_i),
    .status_o       (status_o),
    .active_ch_o    (active_ch_o),
    .pending_o      (pending_o),
    .result_o       (result_o),
    .result_ch_o    (result_ch_o),
    .result_valid_o (result_valid_o),
    .sat_o          (sat_o),
    .err_code_o     (err_code_o)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_status"}, 32'(status_o), 32'(IDLE));
    chk({tag, "_active"}, 32'(active_ch_o), 0);
    chk({tag, "_pending"}, 32'(pending_o), 0);
    chk({tag, "_result"}, result_o, 0);
    chk({tag, "_result_ch"}, 32'(result_ch_o), 0);
    chk({tag, "_valid"}, 32'(result_valid_o), 0);
    chk({tag, "_sat"}, 32'(sat_o), 0);
    chk({tag, "_err"}, 32'(err_code_o), 32'(ERR_NONE));
  endtask

  typedef struct {
    int          ch;
    logic [31:0] data;
    logic [7:0]  iter;
    mode_e       mode;
    logic        dir;
    int          lat;
    status_e     st;
    logic [31:0] res;
    int          res_ch;
    logic        sat;
    err_e        err;
  } vec_t;

  vec_t vt[8];
  vec_t v;
  int   seen;

  initial begin
    vt[0] = '{1, 32'd10,         8'd3,  MODE_WRAP,  1'b0, 3,  DONE,  32'd13,         1, 1'b0, ERR_NONE};
    vt[1] = '{0, 32'hFFFF_FFFE,  8'd4,  MODE_SAT,   1'b0, 4,  DONE,  32'hFFFF_FFFF,  0, 1'b1, ERR_NONE};
    vt[2] = '{0, 32'hFFFF_FFFE,  8'd4,  MODE_WRAP,  1'b0, 4,  DONE,  32'd2,          0, 1'b0, ERR_NONE};
    vt[3] = '{2, 32'd1,          8'd3,  MODE_CHECK, 1'b1, 2,  ERROR, 32'd2,          0, 1'b0, ERR_OVERFLOW};
    vt[4] = '{1, 32'd55,         8'd0,  MODE_WRAP,  1'b0, 0,  ERROR, 32'd2,          0, 1'b0, ERR_ZERO_ITER};
    vt[5] = '{3, 32'd5,          8'd10, MODE_SAT,   1'b1, 10, DONE,  32'd0,          3, 1'b1, ERR_ZERO_ITER};
    vt[6] = '{2, 32'd0,          8'd2,  MODE_WRAP,  1'b1, 2,  DONE,  32'hFFFF_FFFE,  2, 1'b0, ERR_ZERO_ITER};
    vt[7] = '{3, 32'd7,          8'd2,  MODE_CHECK, 1'b0, 2,  DONE,  32'd9,          3, 1'b0, ERR_ZERO_ITER};

    rst_n = 1'b0;
    start_i = '0;
    data_i = '0;
    iter_i = '0;
    mode_i = MODE_WRAP;
    dir_i = 1'b0;
    clear_err_i = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_values("reset");
    rst_n = 1'b1;

    clear_err_i = 1'b1;
    @(negedge clk);
    clear_err_i = 1'b0;
    chk("clear_in_idle", 32'(status_o), 32'(IDLE));

    for (int i = 0; i < 8; i++) begin
      v = vt[i];
      @(negedge clk);
      data_i[v.ch*DW +: DW] = v.data;
      iter_i[v.ch*IW +: IW] = v.iter;
      mode_i = v.mode;
      dir_i = v.dir;
      start_i = '0;
      start_i[v.ch] = 1'b1;
      @(negedge clk);
      start_i = '0;
      chk($sformatf("v%0d_pending", i), 32'(pending_o), 0);
      chk($sformatf("v%0d_active", i), 32'(active_ch_o), v.ch);
      if (v.lat > 0) begin
        repeat (v.lat - 1) @(negedge clk);
        chk($sformatf("v%0d_busy", i), 32'(status_o), 32'(BUSY));
        @(negedge clk);
      end
      chk($sformatf("v%0d_status", i), 32'(status_o), 32'(v.st));
      chk($sformatf("v%0d_valid", i), 32'(result_valid_o), (v.st == DONE) ? 1 : 0);
      chk($sformatf("v%0d_result", i), result_o, v.res);
      chk($sformatf("v%0d_result_ch", i), 32'(result_ch_o), v.res_ch);
      chk($sformatf("v%0d_sat", i), 32'(sat_o), 32'(v.sat));
      chk($sformatf("v%0d_err", i), 32'(err_code_o), 32'(v.err));
      @(negedge clk);
      if (v.st == DONE) begin
        chk($sformatf("v%0d_after_done", i), 32'(status_o), 32'(IDLE));
        chk($sformatf("v%0d_valid_drop", i), 32'(result_valid_o), 0);
      end else begin
        chk($sformatf("v%0d_err_hold", i), 32'(status_o), 32'(ERROR));
        clear_err_i = 1'b1;
        @(negedge clk);
        clear_err_i = 1'b0;
        chk($sformatf("v%0d_cleared", i), 32'(status_o), 32'(IDLE));
        chk($sformatf("v%0d_result_kept", i), result_o, v.res);
      end
    end

    // four simultaneous one-iteration jobs, served 0..3 three cycles apart
    @(negedge clk);
    for (int c = 0; c < NC; c++) begin
      data_i[c*DW +: DW] = 32'(100 + c);
      iter_i[c*IW +: IW] = 8'd1;
    end
    mode_i = MODE_WRAP;
    dir_i = 1'b0;
    start_i = 4'hF;
    @(negedge clk);
    start_i = '0;
    chk("rr_pending", 32'(pending_o), 32'h0000_000E);
    chk("rr_busy", 32'(status_o), 32'(BUSY));
    seen = 0;
    for (int cyc = 1; cyc <= 11; cyc++) begin
      @(negedge clk);
      if (result_valid_o) begin
        chk($sformatf("rr_cyc%0d", seen), cyc, 1 + 3 * seen);
        chk($sformatf("rr_ch%0d", seen), 32'(result_ch_o), seen);
        chk($sformatf("rr_res%0d", seen), result_o, 32'(101 + seen));
        seen++;
      end
    end
    chk("rr_count", seen, 4);

    start_i = 4'b1001;
    @(negedge clk);
    start_i = '0;
    chk("rr2_pending", 32'(pending_o), 32'h0000_0008);
    chk("rr2_active", 32'(active_ch_o), 0);
    seen = 0;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(negedge clk);
      if (result_valid_o) begin
        chk($sformatf("rr2_ch%0d", seen), 32'(result_ch_o), (seen == 0) ? 0 : 3);
        seen++;
      end
    end
    chk("rr2_count", seen, 2);

    // reset in the middle of a long job with ch2 and the active ch1 queued
    @(negedge clk);
    data_i[1*DW +: DW] = '0;
    iter_i[1*IW +: IW] = 8'd20;
    start_i = 4'b0010;
    @(negedge clk);
    start_i = '0;
    repeat (3) @(negedge clk);
    start_i = 4'b0110;
    @(negedge clk);
    start_i = '0;
    chk("mid_pending", 32'(pending_o), 32'h0000_0006);
    chk("mid_busy", 32'(status_o), 32'(BUSY));
    #2 rst_n = 1'b0;
    #1;
    chk_reset_values("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_status", 32'(status_o), 32'(IDLE));
    chk("post_rst_pending", 32'(pending_o), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
